reg_bank_sequencer: RTL and testbench

//  Owns write access to a bank of NREG parallel-load registers (load/clr/d style, clr honoured only with load).

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/reg_bank_sequencer.sv | 139 +++++++++++++
 tb/tb_reg_bank_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and round-robin helper for the register-bank write sequencer.
// Latency: n/a. Backpressure: n/a.
package reg_bank_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Index 'off' positions past 'last' in a ring of n entries; off is 1..n.
   function automatic int rr_rotate(input int last, input int off, input int n);
      int sum;
      sum = last + off;
      return (sum >= n) ? (sum - n) : sum;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one eligible requester, searching from last_idx+1.
// Latency: combinational. Backpressure: none, caller masks eligibility.
module rr_arbiter
   import reg_bank_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
)(
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] last_idx,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int off = 1; off <= N; off++) begin
         idx = IW'(rr_rotate(int'(last_idx), off, N));
         if (!found && eligible[idx]) begin
            found    = 1'b1;
            win[idx] = 1'b1;
            win_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Owns writes to a parallel-load register bank: clear-all walk, then round-robin writes.
// Latency: one cycle req->gnt/strobe. Backpressure: req held until gnt; none granted while busy.
module reg_bank_sequencer
   import reg_bank_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int NREG = 8,
   parameter  int SIZE = 8,
   localparam int AW   = $clog2(NREG),
   localparam int RW   = $clog2(NREQ)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*SIZE-1:0] req_data,
   input  logic [NREQ-1:0]      req_clr,
   input  logic                 clr_all_start,
   output logic [NREQ-1:0]      gnt,
   output logic                 err,
   output logic                 busy,
   output logic [NREG-1:0]      reg_load,
   output logic [NREG-1:0]      reg_clr,
   output logic [SIZE-1:0]      reg_d
);

   localparam logic [AW-1:0]   LAST_IDX = AW'(NREG - 1);
   localparam logic [AW:0]     NREG_W   = (AW + 1)'(NREG);
   localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

   state_e            state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic [RW-1:0]     rr_last_q, rr_last_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              err_q, err_d;
   logic [NREG-1:0]   load_q, load_d;
   logic [NREG-1:0]   rclr_q, rclr_d;
   logic [SIZE-1:0]   regd_q, regd_d;

   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   win;
   logic [RW-1:0]     win_idx;
   logic [AW-1:0]     sel_addr;
   logic [SIZE-1:0]   sel_data;
   logic              sel_clr;

   // A requester sees its gnt one cycle late, so mask it for that cycle.
   assign eligible = req & ~gnt_q;

   rr_arbiter #(.N(NREQ)) u_arb (
      .eligible (eligible),
      .last_idx (rr_last_q),
      .win      (win),
      .win_idx  (win_idx)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_clr  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win[k]) begin
            sel_addr = req_addr[k*AW +: AW];
            sel_data = req_data[k*SIZE +: SIZE];
            sel_clr  = req_clr[k];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      rr_last_d = rr_last_q;
      gnt_d     = '0;
      err_d     = 1'b0;
      load_d    = '0;
      rclr_d    = '0;
      regd_d    = '0;
      case (state_q)
         ST_CLEAR: begin
            load_d = ONE_HOT0 << clr_idx_q;
            rclr_d = ONE_HOT0 << clr_idx_q;
            if (clr_idx_q == LAST_IDX) begin
               state_d   = ST_IDLE;
               clr_idx_d = '0;
            end else begin
               clr_idx_d = clr_idx_q + AW'(1);
            end
         end
         default: begin
            if (clr_all_start) begin
               state_d   = ST_CLEAR;
               clr_idx_d = '0;
            end else if (|win) begin
               gnt_d     = win;
               rr_last_d = win_idx;
               // Out-of-range targets still release the requester, but nothing loads.
               if ({1'b0, sel_addr} < NREG_W) begin
                  load_d = ONE_HOT0 << sel_addr;
                  rclr_d = sel_clr ? (ONE_HOT0 << sel_addr) : '0;
                  regd_d = sel_clr ? '0 : sel_data;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_idx_q <= '0;
         rr_last_q <= RW'(NREQ - 1);
         gnt_q     <= '0;
         err_q     <= 1'b0;
         load_q    <= '0;
         rclr_q    <= '0;
         regd_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         rr_last_q <= rr_last_d;
         gnt_q     <= gnt_d;
         err_q     <= err_d;
         load_q    <= load_d;
         rclr_q    <= rclr_d;
         regd_q    <= regd_d;
      end
   end

   assign gnt      = gnt_q;
   assign err      = err_q;
   assign busy     = (state_q == ST_CLEAR);
   assign reg_load = load_q;
   assign reg_clr  = rclr_q;
   assign reg_d    = regd_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed bench for reg_bank_sequencer: NREG=8 instance (a) and NREG=6 instance (b).
module tb_reg_bank_sequencer;

   localparam int NREQ = 4;
   localparam int SIZE = 8;
   localparam int AWA  = 3;
   localparam int AWB  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [NREQ-1:0]      req_a, rqclr_a, gnt_a;
   logic [NREQ*AWA-1:0]  addr_a;
   logic [NREQ*SIZE-1:0] data_a;
   logic                 start_a, err_a, busy_a;
   logic [7:0]           load_a, rclr_a;
   logic [SIZE-1:0]      d_a;

   logic [NREQ-1:0]      req_b, rqclr_b, gnt_b;
   logic [NREQ*AWB-1:0]  addr_b;
   logic [NREQ*SIZE-1:0] data_b;
   logic                 start_b, err_b, busy_b;
   logic [5:0]           load_b, rclr_b;
   logic [SIZE-1:0]      d_b;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] e;

   always #5 clk = ~clk;

   reg_bank_sequencer #(.NREQ(NREQ), .NREG(8), .SIZE(SIZE)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .req_addr(addr_a), .req_data(data_a),
      .req_clr(rqclr_a), .clr_all_start(start_a), .gnt(gnt_a), .err(err_a),
      .busy(busy_a), .reg_load(load_a), .reg_clr(rclr_a), .reg_d(d_a)
   );

   reg_bank_sequencer #(.NREQ(NREQ), .NREG(6), .SIZE(SIZE)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .req_addr(addr_b), .req_data(data_b),
      .req_clr(rqclr_b), .clr_all_start(start_b), .gnt(gnt_b), .err(err_b),
      .busy(busy_b), .reg_load(load_b), .reg_clr(rclr_b), .reg_d(d_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      req_a = '0; rqclr_a = '0; addr_a = '0; data_a = '0; start_a = 1'b0;
      req_b = '0; rqclr_b = '0; addr_b = '0; data_b = '0; start_b = 1'b0;

      // Reset values
      tick(); tick();
      chk("rst_gnt",  32'(gnt_a),  0);
      chk("rst_err",  32'(err_a),  0);
      chk("rst_busy", 32'(busy_a), 1);
      chk("rst_load", 32'(load_a), 0);
      chk("rst_rclr", 32'(rclr_a), 0);
      chk("rst_d",    32'(d_a),    0);
      rst_n = 1'b1;

      // Clear walk after reset on both instances
      for (int k = 0; k < 8; k++) begin
         tick();
         e = 32'd1 << k;
         chk("walk_a_load", 32'(load_a), e);
         chk("walk_a_rclr", 32'(rclr_a), e);
         chk("walk_a_d",    32'(d_a),    0);
         chk("walk_a_gnt",  32'(gnt_a),  0);
         chk("walk_a_busy", 32'(busy_a), (k < 7) ? 1 : 0);
         chk("walk_b_load", 32'(load_b), (k < 6) ? e : 0);
         chk("walk_b_busy", 32'(busy_b), (k < 5) ? 1 : 0);
      end
      tick();
      chk("walk_a_done_load", 32'(load_a), 0);
      chk("walk_a_done_busy", 32'(busy_a), 0);

      // Fairness: all four held, expect 0,1,2,3,0,1
      addr_a = {3'd7, 3'd6, 3'd5, 3'd4};
      data_a = {8'h13, 8'h12, 8'h11, 8'h10};
      req_a  = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rr_gnt",  32'(gnt_a),  32'd1 << (i % 4));
         chk("rr_load", 32'(load_a), 32'd1 << ((i % 4) + 4));
         chk("rr_d",    32'(d_a),    32'h10 + 32'(i % 4));
      end
      req_a = '0;
      tick();
      chk("rr_idle_gnt",  32'(gnt_a),  0);
      chk("rr_idle_load", 32'(load_a), 0);

      // Single requester held: at most one grant per two cycles
      req_a = 4'b0001;
      tick(); chk("solo_g1", 32'(gnt_a), 1); chk("solo_l1", 32'(load_a), 'h10);
      tick(); chk("solo_g2", 32'(gnt_a), 0); chk("solo_l2", 32'(load_a), 0);
      tick(); chk("solo_g3", 32'(gnt_a), 1);
      tick(); chk("solo_g4", 32'(gnt_a), 0);
      req_a = '0;

      // Single write
      addr_a[2*AWA +: AWA]  = 3'd5;
      data_a[2*SIZE +: SIZE] = 8'hA7;
      req_a = 4'b0100;
      tick();
      chk("wr_gnt",  32'(gnt_a),  'h4);
      chk("wr_load", 32'(load_a), 'h20);
      chk("wr_rclr", 32'(rclr_a), 0);
      chk("wr_d",    32'(d_a),    'hA7);
      chk("wr_err",  32'(err_a),  0);
      req_a = '0;
      tick();
      chk("wr_end_gnt",  32'(gnt_a),  0);
      chk("wr_end_load", 32'(load_a), 0);
      chk("wr_end_d",    32'(d_a),    0);

      // Clear beats data
      addr_a[1*AWA +: AWA]  = 3'd3;
      data_a[1*SIZE +: SIZE] = 8'hFF;
      req_a = 4'b0010; rqclr_a = 4'b0010;
      tick();
      chk("clr_gnt",  32'(gnt_a),  'h2);
      chk("clr_load", 32'(load_a), 'h08);
      chk("clr_rclr", 32'(rclr_a), 'h08);
      chk("clr_d",    32'(d_a),    0);
      req_a = '0; rqclr_a = '0;
      tick();
      chk("clr_end_rclr", 32'(rclr_a), 0);

      // Collision: clear-all wins, request waits for the walk
      req_a = 4'b0001; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("col_gnt0",  32'(gnt_a),  0);
      chk("col_load0", 32'(load_a), 0);
      chk("col_busy0", 32'(busy_a), 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("col_load", 32'(load_a), 32'd1 << k);
         chk("col_gnt",  32'(gnt_a),  0);
         chk("col_busy", 32'(busy_a), (k < 7) ? 1 : 0);
      end
      tick();
      chk("col_gnt_after", 32'(gnt_a),  1);
      chk("col_load_after", 32'(load_a), 'h10);
      chk("col_busy_after", 32'(busy_a), 0);
      req_a = '0;
      tick();
      chk("col_end_gnt", 32'(gnt_a), 0);

      // NREG=6: out-of-range address errors, in-range still loads
      addr_b[1*AWB +: AWB]  = 3'd7;
      data_b[1*SIZE +: SIZE] = 8'hFF;
      req_b = 4'b0010;
      tick();
      chk("oor_gnt",  32'(gnt_b),  'h2);
      chk("oor_err",  32'(err_b),  1);
      chk("oor_load", 32'(load_b), 0);
      req_b = '0;
      tick();
      chk("oor_err_end", 32'(err_b), 0);
      addr_b[0 +: AWB]  = 3'd5;
      data_b[0 +: SIZE] = 8'h3C;
      req_b = 4'b0001;
      tick();
      chk("b5_gnt",  32'(gnt_b),  1);
      chk("b5_err",  32'(err_b),  0);
      chk("b5_load", 32'(load_b), 'h20);
      chk("b5_d",    32'(d_b),    'h3C);
      req_b = '0;

      // Reset mid-walk (a at clr_idx=4) and mid-grant (b)
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick(); tick(); tick();
      addr_b[2*AWB +: AWB] = 3'd2;
      req_b = 4'b0100;
      tick();
      chk("mw_load_pre", 32'(load_a), 'h08);
      chk("mw_b_gnt_pre", 32'(gnt_b), 'h4);
      chk("mw_b_load_pre", 32'(load_b), 'h04);
      rst_n = 1'b0;
      req_b = '0;
      #1;
      chk("mw_rst_load",  32'(load_a), 0);
      chk("mw_rst_rclr",  32'(rclr_a), 0);
      chk("mw_rst_busy",  32'(busy_a), 1);
      chk("mw_rst_b_gnt", 32'(gnt_b),  0);
      chk("mw_rst_b_load", 32'(load_b), 0);
      chk("mw_rst_b_busy", 32'(busy_b), 1);
      #2;
      rst_n = 1'b1;
      tick();
      chk("mw_restart_a", 32'(load_a), 1);
      chk("mw_restart_b", 32'(load_b), 1);
      tick();
      chk("mw_restart_a2", 32'(load_a), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
